// File: rtl/adc_frame_packer_pkg.sv
// rtl/adc_frame_packer_pkg.sv - shared types and constants for the ADC frame packer
package adc_frame_packer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } state_e;

  localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hAD16;
  localparam int          CNT_W             = 32;

  // Saturating increment for the status counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/adc_frame_packer_fifo.sv
// rtl/adc_frame_packer_fifo.sv - single-clock show-ahead FIFO buffering ADC words
module adc_frame_packer_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ok,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             rd_en;

  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign push_ok  = push && (!full || pop);
  assign rd_en    = pop && !empty;
  assign pop_data = mem[rd_ptr_q[AW-1:0]];

  // Next pointer values.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_en)   rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/adc_frame_packer.sv
// rtl/adc_frame_packer.sv - packs ADC sample words into frames; header word enabled by ADC_FRAME_PACKER_HEADER_EN
module adc_frame_packer
  import adc_frame_packer_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] HDR_MAGIC  = HDR_MAGIC_DEFAULT
) (
  input  logic             ACLK,
  input  logic             ARESETN,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [31:0]      s_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic [3:0]       m_axis_tkeep,
  output logic             m_axis_tlast,
  input  logic             enable,
  input  logic [31:0]      frame_len,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

`ifdef ADC_FRAME_PACKER_HEADER_EN
  localparam bit     HDR_EN      = 1'b1;
  localparam state_e START_STATE = ST_HEADER;
`else
  localparam bit     HDR_EN      = 1'b0;
  localparam state_e START_STATE = ST_DATA;
`endif

  state_e           state_q, state_d;
  logic [31:0]      len_q, len_d;
  logic [31:0]      in_cnt_q, in_cnt_d;
  logic [31:0]      out_cnt_q, out_cnt_d;
  logic             m_tvalid_q, m_tvalid_d;
  logic [31:0]      m_tdata_q, m_tdata_d;
  logic             m_tlast_q, m_tlast_d;
  logic [3:0]       m_tkeep_q, m_tkeep_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             s_tready_q;

  logic             fifo_push, fifo_push_ok, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]      fifo_rdata;
  logic             out_free, out_hs, last_hs, capture, next_start, data_phase;
  logic             go_start;
  logic [CNT_W-1:0] hdr_cnt;

  assign out_free   = !m_tvalid_q || m_axis_tready;
  assign out_hs     = m_tvalid_q && m_axis_tready;
  assign last_hs    = (state_q == ST_DATA) && out_hs && m_tlast_q;
  assign next_start = enable && (frame_len != 32'd0);
  // Words are captured only between frame start and the point the frame's quota is buffered.
  assign capture    = (state_q != ST_IDLE) && (in_cnt_q != len_q);
  assign fifo_push  = s_axis_tvalid && s_tready_q && capture;
  assign fifo_pop   = data_phase && out_free && !fifo_empty && (out_cnt_q != len_q);

  adc_frame_packer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .push      (fifo_push),
    .push_data (s_axis_tdata),
    .push_ok   (fifo_push_ok),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Data words may load into the output register in DATA, or in the cycle the header leaves.
  always_comb begin
    data_phase = (state_q == ST_DATA);
`ifdef ADC_FRAME_PACKER_HEADER_EN
    if (state_q == ST_HEADER && out_hs) data_phase = 1'b1;
`endif
  end

  // Frame sequencing, input accounting and output register next-state.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    m_tvalid_d  = m_tvalid_q;
    m_tdata_d   = m_tdata_q;
    m_tlast_d   = m_tlast_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    go_start    = 1'b0;
    hdr_cnt     = frame_cnt_q;

    // Dropped words do not advance the frame's input count.
    if (fifo_push && !fifo_push_ok) drop_cnt_d = sat_inc(drop_cnt_q);
    if (fifo_push_ok)               in_cnt_d   = in_cnt_q + 32'd1;

    if (out_free) begin
      m_tvalid_d = 1'b0;
      m_tlast_d  = 1'b0;
    end
    if (fifo_pop) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = fifo_rdata;
      m_tlast_d  = (out_cnt_q == len_q - 32'd1);
      out_cnt_d  = out_cnt_q + 32'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (next_start) go_start = 1'b1;
      end
`ifdef ADC_FRAME_PACKER_HEADER_EN
      ST_HEADER: begin
        if (out_hs) state_d = ST_DATA;
      end
`endif
      ST_DATA: begin
        if (last_hs) begin
          frame_cnt_d = sat_inc(frame_cnt_q);
          hdr_cnt     = frame_cnt_d;
          if (next_start) go_start = 1'b1;
          else            state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame start latches the length; the header (when built in) carries the completed-frame count.
    if (go_start) begin
      state_d   = START_STATE;
      len_d     = frame_len;
      in_cnt_d  = 32'd0;
      out_cnt_d = 32'd0;
      if (HDR_EN) begin
        m_tvalid_d = 1'b1;
        m_tdata_d  = {HDR_MAGIC, hdr_cnt[15:0]};
        m_tlast_d  = 1'b0;
      end
    end

    busy_d    = (state_d != ST_IDLE);
    m_tkeep_d = m_tvalid_d ? 4'hF : 4'h0;
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tkeep_q   <= 4'h0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      s_tready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
      m_tlast_q   <= m_tlast_d;
      m_tkeep_q   <= m_tkeep_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      s_tready_q  <= 1'b1;
    end
  end

  assign s_axis_tready = s_tready_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign busy          = busy_q;
  assign frame_cnt     = frame_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb/tb_adc_frame_packer.sv - self-checking bench for adc_frame_packer
module tb_adc_frame_packer;

  localparam int DEPTH = 16;
`ifdef ADC_FRAME_PACKER_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] s_tdata = '0;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tlast;
  logic        enable = 1'b0;
  logic [31:0] frame_len = '0;
  logic        busy;
  logic [31:0] frame_cnt;
  logic [31:0] drop_cnt;

  always #5 clk = ~clk;

  adc_frame_packer #(.FIFO_DEPTH(DEPTH), .HDR_MAGIC(16'hAD16)) dut (
    .ACLK          (clk),
    .ARESETN       (rst_n),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .enable        (enable),
    .frame_len     (frame_len),
    .busy          (busy),
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    int len;
    bit stall;
    int exp_fc;
  } vec_t;

  beat_t       exp_q[$];
  int          tests = 0;
  int          fails = 0;
  int          hs_cnt = 0;
  int          wcnt = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;
  bit          rand_ready = 1'b0;
  logic [31:0] exp_fc = '0;
  vec_t        tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = 16'(2 * i);
    hi = 16'(2 * i + 1);
    return {hi, lo};
  endfunction

  // One clock: monitor/scoreboard at the negedge, then return just after the posedge.
  task automatic step();
    @(negedge clk);
    if (rst_n && m_tvalid) begin
      check("tkeep", {28'h0, m_tkeep}, 32'hF);
      if (stall_prev) begin
        check("stall_tdata", m_tdata, prev_data);
        check("stall_tlast", {31'h0, m_tlast}, {31'h0, prev_last});
      end
    end
    if (rst_n && m_tvalid && m_tready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got 0x%08h expected none", m_tdata);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("tdata", m_tdata, e.data);
        check("tlast", {31'h0, m_tlast}, {31'h0, e.last});
      end
    end
    stall_prev = rst_n && m_tvalid && !m_tready;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    @(posedge clk);
    #1;
    if (rand_ready) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_hdr();
    if (HDR) exp_q.push_back({16'hAD16, exp_fc[15:0], 1'b0});
  endtask

  task automatic send(input bit expect_it, input bit last);
    s_tvalid = 1'b1;
    s_tdata  = word(wcnt);
    if (expect_it) exp_q.push_back({word(wcnt), last});
    wcnt++;
    step();
    s_tvalid = 1'b0;
  endtask

  task automatic start_frame(input int len, input logic en_after);
    enable    = 1'b1;
    frame_len = len;
    push_hdr();
    step();
    enable    = en_after;
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy && !m_tvalid && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check({name, "_done"}, {31'h0, done}, 32'd1);
    exp_q.delete();
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check({name, "_drain"}, {31'h0, done}, 32'd1);
  endtask

  initial begin
    int limit;
    int accepted;
    int target;
    int base;

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", {31'h0, m_tvalid}, 32'd0);
    check("rst_tkeep", {28'h0, m_tkeep}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_s_tready", {31'h0, s_tready}, 32'd0);
    check("rst_frame_cnt", frame_cnt, 32'd0);
    check("rst_drop_cnt", drop_cnt, 32'd0);
    rst_n = 1'b1;
    step();
    check("s_tready_after_rst", {31'h0, s_tready}, 32'd1);

    // frame_len=0 with enable held keeps the block idle; idle words are discarded.
    enable    = 1'b1;
    frame_len = 32'd0;
    for (int i = 0; i < 20; i++) begin
      send(1'b0, 1'b0);
      check("len0_tvalid", {31'h0, m_tvalid}, 32'd0);
      check("len0_busy", {31'h0, busy}, 32'd0);
    end
    check("len0_frame_cnt", frame_cnt, 32'd0);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, 1'b0);
    check("idle_drop_cnt", drop_cnt, 32'd0);

    // Table of single frames; frame_len is changed right after start and must be ignored.
    tbl[0] = '{len: 4, stall: 1'b0, exp_fc: 1};
    tbl[1] = '{len: 7, stall: 1'b1, exp_fc: 2};
    tbl[2] = '{len: 1, stall: 1'b1, exp_fc: 3};
    tbl[3] = '{len: 3, stall: 1'b0, exp_fc: 4};
    wcnt = 0;
    for (int r = 0; r < 4; r++) begin
      rand_ready = tbl[r].stall;
      start_frame(tbl[r].len, 1'b0);
      frame_len = tbl[r].len + 3;
      check("tbl_busy", {31'h0, busy}, 32'd1);
      for (int i = 0; i < tbl[r].len; i++) send(1'b1, i == tbl[r].len - 1);
      wait_done("tbl");
      rand_ready = 1'b0;
      m_tready   = 1'b1;
      check("tbl_frame_cnt", frame_cnt, tbl[r].exp_fc);
      check("tbl_drop_cnt", drop_cnt, 32'd0);
      exp_fc = tbl[r].exp_fc;
    end

    // enable dropped after the 2nd data word leaves: frame of 8 still completes.
    base   = hs_cnt;
    target = int'(HDR) + 2;
    start_frame(8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      send(1'b1, i == 7);
      if (hs_cnt - base >= target) enable = 1'b0;
    end
    for (int g = 0; g < 50 && enable; g++) begin
      step();
      if (hs_cnt - base >= target) enable = 1'b0;
    end
    check("en_drop_seen", {31'h0, enable}, 32'd0);
    wait_done("en_drop");
    exp_fc = exp_fc + 1;
    check("en_drop_frame_cnt", frame_cnt, exp_fc);
    check("en_drop_busy", {31'h0, busy}, 32'd0);

    // frame_len=1 with enable held: back-to-back frames, each data word is last.
    start_frame(1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      send(1'b1, 1'b1);
      if (k == 2) enable = 1'b0;
      wait_drain("len1");
      exp_fc = exp_fc + 1;
      check("len1_frame_cnt", frame_cnt, exp_fc);
      if (k < 2) push_hdr();
    end
    wait_done("len1");
    check("len1_busy", {31'h0, busy}, 32'd0);

    // Overflow: output stalled 40 cycles with continuous input, frame_len=64.
    limit    = HDR ? DEPTH : DEPTH + 1;
    accepted = 0;
    m_tready = 1'b0;
    start_frame(64, 1'b0);
    for (int i = 0; accepted < 64 && i < 200; i++) begin
      bit ex;
      if (i == 40) m_tready = 1'b1;
      ex = (i < limit) || (i >= 40);
      send(ex, ex && (accepted == 63));
      if (ex) accepted++;
    end
    wait_done("ovf");
    exp_fc = exp_fc + 1;
    check("ovf_drop_cnt", drop_cnt, 32'(40 - limit));
    check("ovf_frame_cnt", frame_cnt, exp_fc);

    // Reset pulsed after the 3rd data word of a 10-word frame.
    base   = hs_cnt;
    target = int'(HDR) + 3;
    start_frame(10, 1'b0);
    for (int i = 0; i < 10 && (hs_cnt - base) < target; i++) send(1'b1, i == 9);
    check("rst_mid_reached", {31'h0, (hs_cnt - base) >= target}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstm_tvalid", {31'h0, m_tvalid}, 32'd0);
    check("rstm_tlast", {31'h0, m_tlast}, 32'd0);
    check("rstm_tdata", m_tdata, 32'd0);
    check("rstm_tkeep", {28'h0, m_tkeep}, 32'd0);
    check("rstm_busy", {31'h0, busy}, 32'd0);
    check("rstm_frame_cnt", frame_cnt, 32'd0);
    check("rstm_drop_cnt", drop_cnt, 32'd0);
    check("rstm_s_tready", {31'h0, s_tready}, 32'd0);
    exp_q.delete();
    s_tvalid   = 1'b0;
    stall_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    exp_fc = '0;
    step();
    start_frame(2, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    wait_done("post_rst");
    check("post_rst_frame_cnt", frame_cnt, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
